// File: rtl/hazard_ctrl.sv
// hazard_ctrl: E/M/W shadow {reg,Tnew} pipeline and Tuse/Tnew stall generation for the 5-stage MIPS pipeline
//   optional multiply/divide busy stall: define MDU_BUSY_STALL_EN
//   inputs : clk, reset (sync, active-high), d_rs/d_rt + d_tuse_rs/d_tuse_rt (D sources),
//            d_wreg/d_tnew (D destination), flush (bubble into E)
//   outputs: reg_e/m/w + tnew_e/m/w (forwarding-mux feeds), stall, en_pc, en_d, clr_e, stall_cnt
//   MDU_BUSY_STALL_EN adds: e_mdu_start, e_mdu_div, d_uses_mdu (in), mdu_busy (out)
module hazard_ctrl #(
  parameter int TW = 4,
  parameter logic [TW-1:0] TUSE_NONE = 4'd15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [4:0]    d_wreg,
  input  logic [TW-1:0] d_tnew,
  input  logic          flush,
  output logic [TW-1:0] tnew_e,
  output logic [4:0]    reg_e,
  output logic [TW-1:0] tnew_m,
  output logic [4:0]    reg_m,
  output logic [TW-1:0] tnew_w,
  output logic [4:0]    reg_w,
  output logic          stall,
  output logic          en_pc,
  output logic          en_d,
  output logic          clr_e,
`ifdef MDU_BUSY_STALL_EN
  input  logic          e_mdu_start,
  input  logic          e_mdu_div,
  input  logic          d_uses_mdu,
  output logic          mdu_busy,
`endif
  output logic [31:0]   stall_cnt
);
  logic [4:0]    reg_e_q, reg_e_d, reg_m_q, reg_m_d, reg_w_q, reg_w_d;
  logic [TW-1:0] tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d, tnew_w_q, tnew_w_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic          hz;
  function automatic logic [TW-1:0] sat0(input logic [TW-1:0] x);
    return x == '0 ? '0 : x - 1'b1;
  endfunction
  // Register 0 marks a bubble slot, so a zero source address can never match.
  function automatic logic hit(input logic [4:0] a, input logic [TW-1:0] u,
                               input logic [4:0] r, input logic [TW-1:0] t);
    return a != 5'd0 && a == r && u != TUSE_NONE && t > u;
  endfunction
  always_comb begin
    hz = hit(d_rs, d_tuse_rs, reg_e_q, tnew_e_q) | hit(d_rs, d_tuse_rs, reg_m_q, tnew_m_q) |
         hit(d_rt, d_tuse_rt, reg_e_q, tnew_e_q) | hit(d_rt, d_tuse_rt, reg_m_q, tnew_m_q);
  end
`ifdef MDU_BUSY_STALL_EN
  logic [3:0] mdu_cnt_q, mdu_cnt_d;
  assign mdu_busy = mdu_cnt_q != 4'd0;
  // The start cycle itself also stalls an MDU user in D, before the counter is loaded.
  assign stall = hz | (d_uses_mdu & (mdu_busy | e_mdu_start));
  always_comb begin
    mdu_cnt_d = e_mdu_start ? (e_mdu_div ? 4'd10 : 4'd5) : mdu_busy ? mdu_cnt_q - 4'd1 : mdu_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) mdu_cnt_q <= 4'd0;
    else mdu_cnt_q <= mdu_cnt_d;
  end
`else
  assign stall = hz;
`endif
  always_comb begin
    reg_w_d     = reg_m_q;
    tnew_w_d    = sat0(tnew_m_q);
    reg_m_d     = reg_e_q;
    tnew_m_d    = sat0(tnew_e_q);
    reg_e_d     = (stall | flush) ? 5'd0 : d_wreg;
    tnew_e_d    = (stall | flush) ? '0 : d_tnew;
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_e_q     <= 5'd0;
      reg_m_q     <= 5'd0;
      reg_w_q     <= 5'd0;
      tnew_e_q    <= '0;
      tnew_m_q    <= '0;
      tnew_w_q    <= '0;
      stall_cnt_q <= 32'd0;
    end else begin
      reg_e_q     <= reg_e_d;
      reg_m_q     <= reg_m_d;
      reg_w_q     <= reg_w_d;
      tnew_e_q    <= tnew_e_d;
      tnew_m_q    <= tnew_m_d;
      tnew_w_q    <= tnew_w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign reg_e     = reg_e_q;
  assign reg_m     = reg_m_q;
  assign reg_w     = reg_w_q;
  assign tnew_e    = tnew_e_q;
  assign tnew_m    = tnew_m_q;
  assign tnew_w    = tnew_w_q;
  assign stall_cnt = stall_cnt_q;
  assign en_pc     = ~stall;
  assign en_d      = ~stall;
  assign clr_e     = stall | flush;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors checked every cycle against a slot-list model plus literal expectations
module tb_hazard_ctrl;
  logic clk = 0, reset = 1;
  logic [4:0] d_rs = 0, d_rt = 0, d_wreg = 0;
  logic [3:0] d_tuse_rs = 15, d_tuse_rt = 15, d_tnew = 0;
  logic flush = 0;
  logic [3:0] tnew_e, tnew_m, tnew_w;
  logic [4:0] reg_e, reg_m, reg_w;
  logic stall, en_pc, en_d, clr_e;
  logic [31:0] stall_cnt;
`ifdef MDU_BUSY_STALL_EN
  logic e_mdu_start = 0, e_mdu_div = 0, d_uses_mdu = 0, mdu_busy;
  int m_busy = 0;
`endif
  typedef struct packed { logic [4:0] r; logic [3:0] t; } slot_t;
  slot_t pipe [3];
  int unsigned m_cnt = 0;
  bit live = 0;
  int n_chk = 0, n_err = 0;
  hazard_ctrl dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wreg(d_wreg), .d_tnew(d_tnew), .flush(flush),
    .tnew_e(tnew_e), .reg_e(reg_e), .tnew_m(tnew_m), .reg_m(reg_m), .tnew_w(tnew_w), .reg_w(reg_w),
    .stall(stall), .en_pc(en_pc), .en_d(en_d), .clr_e(clr_e),
`ifdef MDU_BUSY_STALL_EN
    .e_mdu_start(e_mdu_start), .e_mdu_div(e_mdu_div), .d_uses_mdu(d_uses_mdu), .mdu_busy(mdu_busy),
`endif
    .stall_cnt(stall_cnt));
  always #5 clk = ~clk;
  // A source waits if either of the two youngest producers still has more cycles to go than it can tolerate.
  function automatic bit src_waits(logic [4:0] a, logic [3:0] u);
    bit w = 0;
    if (a == 0 || u == 15) return 0;
    for (int i = 0; i < 2; i++) if (pipe[i].r == a && pipe[i].t > u) w = 1;
    return w;
  endfunction
  function automatic bit m_stall();
    bit s;
    s = src_waits(d_rs, d_tuse_rs) || src_waits(d_rt, d_tuse_rt);
`ifdef MDU_BUSY_STALL_EN
    s = s || (d_uses_mdu && (m_busy > 0 || e_mdu_start));
`endif
    return s;
  endfunction
  function automatic logic [3:0] dec(logic [3:0] t);
    return t > 0 ? t - 1 : 0;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      live <= 1;
      for (int i = 0; i < 3; i++) pipe[i] <= '0;
      m_cnt <= 0;
`ifdef MDU_BUSY_STALL_EN
      m_busy <= 0;
`endif
    end else begin
      if (m_stall()) m_cnt <= m_cnt + 1;
      pipe[2] <= {pipe[1].r, dec(pipe[1].t)};
      pipe[1] <= {pipe[0].r, dec(pipe[0].t)};
      pipe[0] <= (m_stall() || flush) ? '0 : {d_wreg, d_tnew};
`ifdef MDU_BUSY_STALL_EN
      m_busy <= e_mdu_start ? (e_mdu_div ? 10 : 5) : (m_busy > 0 ? m_busy - 1 : 0);
`endif
    end
  end
  always @(negedge clk) begin
    bit s;
    if (live) begin
      s = m_stall();
      chk("stall", stall, s);
      chk("en_pc", en_pc, !s);
      chk("en_d", en_d, !s);
      chk("clr_e", clr_e, s || flush);
      chk("reg_e", reg_e, pipe[0].r);
      chk("tnew_e", tnew_e, pipe[0].t);
      chk("reg_m", reg_m, pipe[1].r);
      chk("tnew_m", tnew_m, pipe[1].t);
      chk("reg_w", reg_w, pipe[2].r);
      chk("tnew_w", tnew_w, pipe[2].t);
      chk("stall_cnt", stall_cnt, m_cnt);
`ifdef MDU_BUSY_STALL_EN
      chk("mdu_busy", mdu_busy, m_busy != 0);
`endif
    end
  end
  task automatic set_in(logic [4:0] rs, logic [4:0] rt, logic [3:0] urs, logic [3:0] urt,
                        logic [4:0] wreg, logic [3:0] tnew, logic fl);
    d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt; d_wreg = wreg; d_tnew = tnew; flush = fl;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    set_in(0, 0, 15, 15, 0, 0, 0);
    repeat (3) tick();
  endtask
  typedef struct packed { logic [4:0] rs, rt; logic [3:0] urs, urt; logic [4:0] wreg; logic [3:0] tnew; logic fl; } vec_t;
  vec_t tbl [10];
  initial begin
    tbl[0] = {5'd2, 5'd0, 4'd15, 4'd15, 5'd7, 4'd2, 1'b0};
    tbl[1] = {5'd0, 5'd7, 4'd15, 4'd1, 5'd8, 4'd1, 1'b0};
    tbl[2] = {5'd0, 5'd7, 4'd15, 4'd1, 5'd8, 4'd1, 1'b0};
    tbl[3] = {5'd8, 5'd7, 4'd0, 4'd2, 5'd9, 4'd0, 1'b0};
    tbl[4] = {5'd9, 5'd8, 4'd0, 4'd0, 5'd31, 4'd2, 1'b0};
    tbl[5] = {5'd31, 5'd31, 4'd15, 4'd2, 5'd4, 4'd1, 1'b0};
    tbl[6] = {5'd4, 5'd31, 4'd1, 4'd0, 5'd4, 4'd2, 1'b1};
    tbl[7] = {5'd4, 5'd0, 4'd0, 4'd0, 5'd5, 4'd2, 1'b0};
    tbl[8] = {5'd5, 5'd5, 4'd1, 4'd0, 5'd0, 4'd0, 1'b0};
    tbl[9] = {5'd5, 5'd5, 4'd1, 4'd0, 5'd0, 4'd0, 1'b0};
    repeat (2) tick();
    reset = 0;
    #2 chk("rst_cnt", stall_cnt, 0);
    chk("rst_reg_e", reg_e, 0);
    chk("rst_stall", stall, 0);
    idle();
    set_in(0, 0, 15, 15, 1, 2, 0); tick();
    set_in(1, 0, 1, 15, 3, 1, 0);
    #2 chk("lw_alu_stall", stall, 1);
    chk("lw_alu_clr_e", clr_e, 1);
    tick();
    #2 chk("lw_alu_release", stall, 0);
    chk("lw_alu_reg_m", reg_m, 1);
    chk("lw_alu_tnew_m", tnew_m, 1);
    tick();
    chk("lw_alu_cnt", stall_cnt, 1);
    chk("lw_alu_reg_e", reg_e, 3);
    idle();
    set_in(0, 0, 15, 15, 1, 2, 0); tick();
    set_in(1, 0, 0, 15, 0, 0, 0);
    #2 chk("lw_beq_stall1", stall, 1);
    tick();
    #2 chk("lw_beq_stall2", stall, 1);
    chk("lw_beq_tnew_m", tnew_m, 1);
    tick();
    #2 chk("lw_beq_release", stall, 0);
    chk("lw_beq_reg_w", reg_w, 1);
    chk("lw_beq_tnew_w", tnew_w, 0);
    tick();
    chk("lw_beq_cnt", stall_cnt, 3);
    idle();
    set_in(0, 0, 15, 15, 1, 1, 0); tick();
    set_in(0, 1, 15, 2, 0, 0, 0);
    #2 chk("alu_sw_stall", stall, 0);
    chk("alu_sw_reg_e", reg_e, 1);
    chk("alu_sw_tnew_e", tnew_e, 1);
    tick();
    #2 chk("alu_sw_reg_m", reg_m, 1);
    chk("alu_sw_tnew_m", tnew_m, 0);
    idle();
    set_in(0, 0, 15, 15, 0, 2, 0); tick();
    set_in(0, 0, 0, 15, 0, 0, 0);
    #2 chk("r0_stall", stall, 0);
    idle();
    set_in(0, 0, 15, 15, 5, 1, 1);
    #2 chk("flush_en_pc", en_pc, 1);
    chk("flush_clr_e", clr_e, 1);
    tick();
    chk("flush_reg_e", reg_e, 0);
    chk("flush_tnew_e", tnew_e, 0);
    idle();
    set_in(0, 0, 15, 15, 1, 2, 0); tick();
    set_in(1, 0, 1, 15, 3, 1, 1);
    #2 chk("flush_hz_stall", stall, 1);
    tick();
    set_in(1, 0, 1, 15, 3, 1, 0);
    #2 chk("flush_hz_release", stall, 0);
    chk("flush_hz_bubble", reg_e, 0);
    tick();
    chk("flush_hz_reg_e", reg_e, 3);
    chk("flush_hz_cnt", stall_cnt, 4);
    idle();
    foreach (tbl[i]) begin
      set_in(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].wreg, tbl[i].tnew, tbl[i].fl);
      tick();
    end
    idle();
    set_in(0, 0, 15, 15, 1, 2, 0); tick();
    set_in(1, 0, 0, 15, 0, 0, 0);
    reset = 1;
    #2 chk("rst_mid_stall", stall, 1);
    tick();
    chk("rst_mid_release", stall, 0);
    chk("rst_mid_cnt", stall_cnt, 0);
    chk("rst_mid_reg_m", reg_m, 0);
    chk("rst_mid_reg_e", reg_e, 0);
    reset = 0;
    idle();
`ifdef MDU_BUSY_STALL_EN
    for (int k = 0; k < 2; k++) begin
      int n;
      n = 0;
      d_uses_mdu = 1; e_mdu_start = 1; e_mdu_div = (k == 0);
      for (int c = 0; c < 14; c++) begin
        #2 if (stall) n++;
        tick();
        e_mdu_start = 0;
      end
      chk(k == 0 ? "div_stall_cycles" : "mult_stall_cycles", n, k == 0 ? 11 : 6);
      d_uses_mdu = 0;
      idle();
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
